// File: rtl/dsp_mem_pkg.sv
// Shared types and helpers for the data-memory port arbiter and its
// response tracker.
package dsp_mem_pkg;

  // Access width encodings on the *_width buses.
  localparam logic [2:0] MW_BYTE = 3'b000;
  localparam logic [2:0] MW_HALF = 3'b001;
  localparam logic [2:0] MW_WORD = 3'b010;

  // Arbiter state: ARB = normal priority arbitration, LOCK = DSP burst owns the port.
  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  // Which requester owns an access or a response.
  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DSP = 1'b1
  } owner_e;

  // True when the byte address falls outside the data memory.
  // The check uses the word index only, so the byte lanes are ignored.
  function automatic logic word_out_of_range(input logic [31:0] addr,
                                             input int unsigned words);
    return {2'b00, addr[31:2]} >= words;
  endfunction

endpackage

// File: rtl/dmem_resp_tracker.sv
// One-deep response pipeline. It remembers the owner and error status of the
// read granted last cycle. It steers the registered memory read data to that
// owner, and forces zero data on an error.
module dmem_resp_tracker
  import dsp_mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        issue_valid,
  input  owner_e      issue_owner,
  input  logic        issue_err,
  input  logic [31:0] mem_rdata,
  output logic        cpu_rvalid,
  output logic [31:0] cpu_rdata,
  output logic        cpu_rerr,
  output logic        dsp_rvalid,
  output logic [31:0] dsp_rdata,
  output logic        dsp_rerr
);

  logic   valid_q, valid_d;
  owner_e owner_q, owner_d;
  logic   err_q,   err_d;

  // Capture the read issued this cycle; an empty slot carries a clean owner/err.
  always_comb begin
    valid_d = issue_valid;
    owner_d = OWN_CPU;
    err_d   = 1'b0;
    if (issue_valid) begin
      owner_d = issue_owner;
      err_d   = issue_err;
    end
  end

  // Response slot register; reset drops any in-flight response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      owner_q <= OWN_CPU;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      owner_q <= owner_d;
      err_q   <= err_d;
    end
  end

  // Route the response to its owner; the non-owner always sees zero data.
  always_comb begin
    cpu_rvalid = valid_q && (owner_q == OWN_CPU);
    dsp_rvalid = valid_q && (owner_q == OWN_DSP);
    cpu_rerr   = cpu_rvalid && err_q;
    dsp_rerr   = dsp_rvalid && err_q;
    cpu_rdata  = (cpu_rvalid && !err_q) ? mem_rdata : 32'h0;
    dsp_rdata  = (dsp_rvalid && !err_q) ? mem_rdata : 32'h0;
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single data-memory port between the CPU load/store unit (port 0)
// and the DSP stream engine (port 1). The CPU has fixed priority. A starvation
// counter forces a DSP grant after MAX_WAIT denied cycles. The DSP may also lock
// the port for a burst of up to BURST_MAX grants.
//
// Handshake: a requester raises *_req with all of its fields and holds them
// stable until it sees *_gnt high in the same cycle. gnt is combinational, and
// at most one gnt is high per cycle. A granted write is complete in the gnt
// cycle. A granted read returns *_rvalid/*_rdata exactly one cycle later; there
// is no back-pressure on responses.
module dmem_port_arbiter
  import dsp_mem_pkg::*;
#(
  parameter int unsigned MAX_WAIT   = 8,
  parameter int unsigned BURST_MAX  = 16,
  parameter int unsigned DMEM_WORDS = 2048
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [2:0]  cpu_width,
  input  logic        cpu_signed,
  output logic        cpu_gnt,
  output logic        cpu_rvalid,
  output logic [31:0] cpu_rdata,
  output logic        cpu_err,
  input  logic        dsp_req,
  input  logic        dsp_we,
  input  logic [31:0] dsp_addr,
  input  logic [31:0] dsp_wdata,
  input  logic [2:0]  dsp_width,
  input  logic        dsp_signed,
  input  logic        dsp_lock,
  input  logic        dsp_circ,
  input  logic        dsp_bitrev,
  input  logic [31:0] dsp_base,
  input  logic [31:0] dsp_bufsize,
  input  logic [4:0]  dsp_fftlog2,
  output logic        dsp_gnt,
  output logic        dsp_rvalid,
  output logic [31:0] dsp_rdata,
  output logic        dsp_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_width,
  output logic        mem_signed,
  output logic        mem_circ,
  output logic        mem_bitrev,
  output logic [31:0] mem_base,
  output logic [31:0] mem_bufsize,
  output logic [4:0]  mem_fftlog2,
  input  logic [31:0] mem_rdata,
  output arb_state_e  dbg_state,
  output logic [7:0]  dbg_wait_cnt,
  output logic [7:0]  dbg_burst_cnt
);

  localparam logic [7:0] MAX_WAIT_C  = 8'(MAX_WAIT);
  localparam logic [7:0] BURST_MAX_C = 8'(BURST_MAX);

  arb_state_e state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic [7:0] burst_cnt_q, burst_cnt_d;

  logic cpu_oor, dsp_oor;
  logic sel_we, sel_oor;
  logic cpu_rerr, dsp_rerr;
  logic issue_read;

  // Circular and bit-reverse addresses are computed inside the memory, so the
  // DSP range check only applies to plain linear accesses.
  assign cpu_oor = word_out_of_range(cpu_addr, DMEM_WORDS);
  assign dsp_oor = word_out_of_range(dsp_addr, DMEM_WORDS) && !dsp_circ && !dsp_bitrev;

  // Grant decision: DSP owns LOCK. In ARB the CPU wins unless the DSP has starved.
  always_comb begin
    cpu_gnt = 1'b0;
    dsp_gnt = 1'b0;
    if (state_q == LOCK) begin
      dsp_gnt = dsp_req;
    end else if (dsp_req && (!cpu_req || wait_cnt_q == MAX_WAIT_C)) begin
      dsp_gnt = 1'b1;
    end else begin
      cpu_gnt = cpu_req;
    end
  end

  // Next state, burst counter and starvation counter.
  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    wait_cnt_d  = wait_cnt_q;

    if (dsp_gnt || !dsp_req) begin
      wait_cnt_d = 8'd0;
    end else if (wait_cnt_q < MAX_WAIT_C) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end

    case (state_q)
      ARB: begin
        burst_cnt_d = 8'd0;
        // With BURST_MAX of 1 the first locked grant already ends the burst.
        if (dsp_gnt && dsp_lock && (BURST_MAX_C > 8'd1)) begin
          state_d     = LOCK;
          burst_cnt_d = 8'd1;
        end
      end
      LOCK: begin
        if (!dsp_lock) begin
          state_d     = ARB;
          burst_cnt_d = 8'd0;
        end else if (dsp_gnt) begin
          if (burst_cnt_q + 8'd1 >= BURST_MAX_C) begin
            state_d     = ARB;
            burst_cnt_d = 8'd0;
          end else begin
            burst_cnt_d = burst_cnt_q + 8'd1;
          end
        end
      end
      default: begin
        state_d     = ARB;
        burst_cnt_d = 8'd0;
      end
    endcase
  end

  // Arbiter state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB;
      wait_cnt_q  <= 8'd0;
      burst_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  // Memory-side mux: the winner's fields, or all zero when nobody is granted.
  always_comb begin
    mem_addr    = 32'h0;
    mem_wdata   = 32'h0;
    mem_width   = 3'b000;
    mem_signed  = 1'b0;
    mem_circ    = 1'b0;
    mem_bitrev  = 1'b0;
    mem_base    = 32'h0;
    mem_bufsize = 32'h0;
    mem_fftlog2 = 5'd0;
    sel_we      = 1'b0;
    sel_oor     = 1'b0;
    if (cpu_gnt) begin
      mem_addr   = cpu_addr;
      mem_wdata  = cpu_wdata;
      mem_width  = cpu_width;
      mem_signed = cpu_signed;
      sel_we     = cpu_we;
      sel_oor    = cpu_oor;
    end else if (dsp_gnt) begin
      mem_addr    = dsp_addr;
      mem_wdata   = dsp_wdata;
      mem_width   = dsp_width;
      mem_signed  = dsp_signed;
      mem_circ    = dsp_circ;
      mem_bitrev  = dsp_bitrev;
      mem_base    = dsp_base;
      mem_bufsize = dsp_bufsize;
      mem_fftlog2 = dsp_fftlog2;
      sel_we      = dsp_we;
      sel_oor     = dsp_oor;
    end
    mem_read  = (cpu_gnt || dsp_gnt) && !sel_we && !sel_oor;
    mem_write = (cpu_gnt || dsp_gnt) &&  sel_we && !sel_oor;
  end

  // Any granted read, including an out-of-range one, gets a response slot.
  assign issue_read = (cpu_gnt && !cpu_we) || (dsp_gnt && !dsp_we);

  dmem_resp_tracker u_resp (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_valid (issue_read),
    .issue_owner (dsp_gnt ? OWN_DSP : OWN_CPU),
    .issue_err   (dsp_gnt ? dsp_oor : cpu_oor),
    .mem_rdata   (mem_rdata),
    .cpu_rvalid  (cpu_rvalid),
    .cpu_rdata   (cpu_rdata),
    .cpu_rerr    (cpu_rerr),
    .dsp_rvalid  (dsp_rvalid),
    .dsp_rdata   (dsp_rdata),
    .dsp_rerr    (dsp_rerr)
  );

  // Write errors report with gnt; read errors report with rvalid.
  assign cpu_err = (cpu_gnt && cpu_we && cpu_oor) || cpu_rerr;
  assign dsp_err = (dsp_gnt && dsp_we && dsp_oor) || dsp_rerr;

  assign dbg_state     = state_q;
  assign dbg_wait_cnt  = wait_cnt_q;
  assign dbg_burst_cnt = burst_cnt_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter with MAX_WAIT=8, BURST_MAX=4, DMEM_WORDS=2048.
module tb_dmem_port_arbiter;
  import dsp_mem_pkg::*;

  logic        clk, rst_n;
  logic        cpu_req, cpu_we, cpu_signed;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [2:0]  cpu_width;
  logic        cpu_gnt, cpu_rvalid, cpu_err;
  logic [31:0] cpu_rdata;
  logic        dsp_req, dsp_we, dsp_signed, dsp_lock, dsp_circ, dsp_bitrev;
  logic [31:0] dsp_addr, dsp_wdata, dsp_base, dsp_bufsize;
  logic [2:0]  dsp_width;
  logic [4:0]  dsp_fftlog2;
  logic        dsp_gnt, dsp_rvalid, dsp_err;
  logic [31:0] dsp_rdata;
  logic        mem_read, mem_write, mem_signed, mem_circ, mem_bitrev;
  logic [31:0] mem_addr, mem_wdata, mem_base, mem_bufsize, mem_rdata;
  logic [2:0]  mem_width;
  logic [4:0]  mem_fftlog2;
  arb_state_e  dbg_state;
  logic [7:0]  dbg_wait_cnt, dbg_burst_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Expected read responses per port: {err, data}.
  logic [32:0] cpu_exp_q[$];
  logic [32:0] dsp_exp_q[$];

  logic [31:0] tb_mem [0:2047];

  dmem_port_arbiter #(.MAX_WAIT(8), .BURST_MAX(4), .DMEM_WORDS(2048)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_width(cpu_width), .cpu_signed(cpu_signed),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .dsp_req(dsp_req), .dsp_we(dsp_we), .dsp_addr(dsp_addr), .dsp_wdata(dsp_wdata),
    .dsp_width(dsp_width), .dsp_signed(dsp_signed), .dsp_lock(dsp_lock),
    .dsp_circ(dsp_circ), .dsp_bitrev(dsp_bitrev), .dsp_base(dsp_base),
    .dsp_bufsize(dsp_bufsize), .dsp_fftlog2(dsp_fftlog2),
    .dsp_gnt(dsp_gnt), .dsp_rvalid(dsp_rvalid), .dsp_rdata(dsp_rdata), .dsp_err(dsp_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_width(mem_width), .mem_signed(mem_signed), .mem_circ(mem_circ),
    .mem_bitrev(mem_bitrev), .mem_base(mem_base), .mem_bufsize(mem_bufsize),
    .mem_fftlog2(mem_fftlog2), .mem_rdata(mem_rdata),
    .dbg_state(dbg_state), .dbg_wait_cnt(dbg_wait_cnt), .dbg_burst_cnt(dbg_burst_cnt)
  );

  // Clock and reset-time defaults.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered memory model: one-cycle read latency.
  always @(posedge clk) begin
    if (mem_read) mem_rdata <= tb_mem[mem_addr[12:2]];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; cpu_width = MW_WORD; cpu_signed = 0;
    dsp_req = 0; dsp_we = 0; dsp_addr = 0; dsp_wdata = 0; dsp_width = MW_WORD; dsp_signed = 0;
    dsp_lock = 0; dsp_circ = 0; dsp_bitrev = 0; dsp_base = 0; dsp_bufsize = 0; dsp_fftlog2 = 0;
  endtask

  task automatic cpu_drive(input logic we, input logic [31:0] addr, input logic [31:0] wd);
    cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd; cpu_width = MW_WORD;
  endtask

  task automatic dsp_drive(input logic we, input logic [31:0] addr, input logic [31:0] wd);
    dsp_req = 1; dsp_we = we; dsp_addr = addr; dsp_wdata = wd; dsp_width = MW_WORD;
  endtask

  task automatic chk_all_idle(input string tag);
    chk({tag, "_cpu_gnt"},    32'(cpu_gnt), 0);
    chk({tag, "_dsp_gnt"},    32'(dsp_gnt), 0);
    chk({tag, "_cpu_rvalid"}, 32'(cpu_rvalid), 0);
    chk({tag, "_dsp_rvalid"}, 32'(dsp_rvalid), 0);
    chk({tag, "_cpu_err"},    32'(cpu_err), 0);
    chk({tag, "_dsp_err"},    32'(dsp_err), 0);
    chk({tag, "_mem_read"},   32'(mem_read), 0);
    chk({tag, "_mem_write"},  32'(mem_write), 0);
    chk({tag, "_cpu_rdata"},  cpu_rdata, 0);
    chk({tag, "_dsp_rdata"},  dsp_rdata, 0);
    chk({tag, "_state"},      32'(dbg_state), 32'(ARB));
    chk({tag, "_wait_cnt"},   32'(dbg_wait_cnt), 0);
    chk({tag, "_burst_cnt"},  32'(dbg_burst_cnt), 0);
  endtask

  // Scoreboard monitor: every rvalid pops the owner's expected queue.
  always @(negedge clk) begin
    if (cpu_rvalid) begin
      if (cpu_exp_q.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL cpu_unexpected_rvalid: actual=%h required=none", cpu_rdata);
      end else begin
        logic [32:0] e;
        e = cpu_exp_q.pop_front();
        chk("cpu_rdata", cpu_rdata, e[31:0]);
        chk("cpu_rerr", 32'(cpu_err), 32'(e[32]));
        chk("cpu_resp_dsp_rdata", dsp_rdata, 0);
      end
    end
    if (dsp_rvalid) begin
      if (dsp_exp_q.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL dsp_unexpected_rvalid: actual=%h required=none", dsp_rdata);
      end else begin
        logic [32:0] e;
        e = dsp_exp_q.pop_front();
        chk("dsp_rdata", dsp_rdata, e[31:0]);
        chk("dsp_rerr", 32'(dsp_err), 32'(e[32]));
        chk("dsp_resp_cpu_rdata", cpu_rdata, 0);
      end
    end
  end

  // Directed stimulus with in-cycle grant/mux checks.
  initial begin
    for (int i = 0; i < 2048; i++) tb_mem[i] = 32'(i) ^ 32'h5A5A0000;
    tb_mem[64]   = 32'hDEADBEEF;
    tb_mem[17]   = 32'h11112222;
    tb_mem[2047] = 32'hCAFEF00D;
    tb_mem[1024] = 32'h0BADCAFE;
    mem_rdata = 32'h0;
    rst_n = 0;
    idle_inputs();

    // Reset state
    @(negedge clk);
    chk_all_idle("reset");
    next_cycle();
    rst_n = 1;

    // CPU-only read of 0x100
    cpu_drive(0, 32'h100, 0);
    @(negedge clk);
    chk("t1_cpu_gnt", 32'(cpu_gnt), 1);
    chk("t1_dsp_gnt", 32'(dsp_gnt), 0);
    chk("t1_mem_read", 32'(mem_read), 1);
    chk("t1_mem_addr", mem_addr, 32'h100);
    cpu_exp_q.push_back({1'b0, 32'hDEADBEEF});
    next_cycle();
    idle_inputs();
    @(negedge clk);
    chk("t1_dsp_rvalid", 32'(dsp_rvalid), 0);

    // Contention: DSP wins every 9th cycle
    next_cycle();
    cpu_drive(1, 32'h200, 32'hAAAA0001);
    dsp_drive(1, 32'h300, 32'hBBBB0002);
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      chk($sformatf("cont_cpu_gnt_%0d", k), 32'(cpu_gnt), (k % 9 == 0) ? 0 : 1);
      chk($sformatf("cont_dsp_gnt_%0d", k), 32'(dsp_gnt), (k % 9 == 0) ? 1 : 0);
      chk($sformatf("cont_mem_addr_%0d", k), mem_addr, (k % 9 == 0) ? 32'h300 : 32'h200);
      next_cycle();
    end
    idle_inputs();

    // Burst lock, BURST_MAX = 4
    next_cycle();
    dsp_drive(1, 32'h300, 32'hBBBB0003);
    dsp_lock = 1;
    @(negedge clk);
    chk("burst_dsp_gnt_1", 32'(dsp_gnt), 1);
    next_cycle();
    cpu_drive(1, 32'h200, 32'hAAAA0004);
    for (int k = 2; k <= 5; k++) begin
      @(negedge clk);
      chk($sformatf("burst_dsp_gnt_%0d", k), 32'(dsp_gnt), (k <= 4) ? 1 : 0);
      chk($sformatf("burst_cpu_gnt_%0d", k), 32'(cpu_gnt), (k <= 4) ? 0 : 1);
      chk($sformatf("burst_state_%0d", k), 32'(dbg_state), (k <= 4) ? 32'(LOCK) : 32'(ARB));
      next_cycle();
    end
    idle_inputs();

    // Out of range accesses and the last valid word
    next_cycle();
    cpu_drive(0, 32'h2000, 0);
    @(negedge clk);
    chk("oor_rd_cpu_gnt", 32'(cpu_gnt), 1);
    chk("oor_rd_mem_read", 32'(mem_read), 0);
    chk("oor_rd_err_early", 32'(cpu_err), 0);
    cpu_exp_q.push_back({1'b1, 32'h0});
    next_cycle();
    idle_inputs();
    dsp_drive(1, 32'h2000, 32'h12345678);
    dsp_circ = 1; dsp_base = 32'h40; dsp_bufsize = 32'h20;
    @(negedge clk);
    chk("circ_wr_dsp_gnt", 32'(dsp_gnt), 1);
    chk("circ_wr_mem_write", 32'(mem_write), 1);
    chk("circ_wr_dsp_err", 32'(dsp_err), 0);
    next_cycle();
    dsp_circ = 0; dsp_base = 0; dsp_bufsize = 0;
    @(negedge clk);
    chk("oor_wr_dsp_gnt", 32'(dsp_gnt), 1);
    chk("oor_wr_mem_write", 32'(mem_write), 0);
    chk("oor_wr_dsp_err", 32'(dsp_err), 1);
    next_cycle();
    idle_inputs();
    cpu_drive(1, 32'h2004, 32'h1);
    @(negedge clk);
    chk("oor_wr_cpu_err", 32'(cpu_err), 1);
    chk("oor_wr_cpu_mem_write", 32'(mem_write), 0);
    next_cycle();
    cpu_drive(0, 32'h1FFC, 0);
    @(negedge clk);
    chk("last_word_mem_read", 32'(mem_read), 1);
    cpu_exp_q.push_back({1'b0, 32'hCAFEF00D});
    next_cycle();
    idle_inputs();

    // DSP circular read then CPU read: mode fields follow the owner
    dsp_drive(0, 32'h44, 0);
    dsp_circ = 1; dsp_base = 32'h40; dsp_bufsize = 32'h20;
    @(negedge clk);
    chk("circ_mem_read", 32'(mem_read), 1);
    chk("circ_mem_circ", 32'(mem_circ), 1);
    chk("circ_mem_base", mem_base, 32'h40);
    chk("circ_mem_bufsize", mem_bufsize, 32'h20);
    dsp_exp_q.push_back({1'b0, 32'h11112222});
    next_cycle();
    idle_inputs();
    cpu_drive(0, 32'h100, 0);
    @(negedge clk);
    chk("after_circ_cpu_gnt", 32'(cpu_gnt), 1);
    chk("after_circ_mem_circ", 32'(mem_circ), 0);
    chk("after_circ_mem_base", mem_base, 0);
    chk("after_circ_mem_bufsize", mem_bufsize, 0);
    cpu_exp_q.push_back({1'b0, 32'hDEADBEEF});
    next_cycle();
    idle_inputs();
    dsp_drive(0, 32'h3000, 0);
    dsp_bitrev = 1; dsp_fftlog2 = 5'd5;
    @(negedge clk);
    chk("bitrev_mem_read", 32'(mem_read), 1);
    chk("bitrev_mem_bitrev", 32'(mem_bitrev), 1);
    chk("bitrev_mem_fftlog2", 32'(mem_fftlog2), 5);
    dsp_exp_q.push_back({1'b0, 32'h0BADCAFE});
    next_cycle();
    idle_inputs();

    // Reset right after a read grant: the response must vanish
    cpu_drive(1, 32'h200, 32'h7);
    dsp_drive(1, 32'h300, 32'h8);
    next_cycle();
    next_cycle();
    cpu_drive(0, 32'h100, 0);
    @(negedge clk);
    chk("rst_pre_cpu_gnt", 32'(cpu_gnt), 1);
    chk("rst_pre_wait_cnt", 32'(dbg_wait_cnt), 2);
    next_cycle();
    rst_n = 0;
    idle_inputs();
    @(negedge clk);
    chk("rst_mid_cpu_rvalid", 32'(cpu_rvalid), 0);
    chk("rst_mid_cpu_rdata", cpu_rdata, 0);
    next_cycle();
    next_cycle();
    rst_n = 1;
    @(negedge clk);
    chk_all_idle("post_rst");

    repeat (3) next_cycle();
    chk("cpu_exp_q_drained", 32'(cpu_exp_q.size()), 0);
    chk("dsp_exp_q_drained", 32'(dsp_exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
